// File: rtl/puf_pkg.sv
// Shared FSM state encoding and derived-width helpers for the PUF hash engine.
package puf_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_PUF_REQ   = 3'd1;
  localparam state_t ST_PUF_WAIT  = 3'd2;
  localparam state_t ST_HASH_REQ  = 3'd3;
  localparam state_t ST_HASH_WAIT = 3'd4;
  localparam state_t ST_DONE      = 3'd5;

  function automatic int unsigned hash_in_width(input int unsigned chal_w,
                                                input int unsigned resp_w,
                                                input int unsigned n_chal);
    return chal_w + n_chal * resp_w;
  endfunction

  function automatic int unsigned sel_width(input int unsigned n_slice);
    return $clog2(n_slice + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n_chal);
    return (n_chal > 1) ? $clog2(n_chal) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/puf_disp_mux.sv
// Registered display selector: sel 0 shows {base, response}, 1..N_SLICE show digest slices.
module puf_disp_mux
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W   = 8,
  parameter int unsigned RESP_W   = 8,
  parameter int unsigned DIGEST_W = 128,
  parameter int unsigned DISP_W   = 16,
  parameter int unsigned SEL_W    = sel_width(DIGEST_W / DISP_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHAL_W-1:0]   base,
  input  logic [RESP_W-1:0]   response,
  input  logic [DIGEST_W-1:0] digest,
  input  logic [SEL_W-1:0]    sel,
  output logic [DISP_W-1:0]   disp
);

  localparam int unsigned N_SLICE = DIGEST_W / DISP_W;

  logic [CHAL_W+RESP_W-1:0] raw;
  logic [DISP_W-1:0]        disp_d;

  assign raw = {base, response};

  always_comb begin
    disp_d = '0;
    if (sel == '0) begin
      disp_d = DISP_W'(raw);
    end else begin
      for (int i = 1; i <= N_SLICE; i++) begin
        if (sel == SEL_W'(i)) disp_d = digest[i*DISP_W-1 -: DISP_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) disp <= '0;
    else       disp <= disp_d;
  end

endmodule

// File: rtl/puf_hash_engine.sv
// Challenge/response sequencer: queries an external PUF (single or batch),
// feeds the packed results to a hash core and exposes digest slices for display.
module puf_hash_engine
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W   = 8,
  parameter int unsigned RESP_W   = 8,
  parameter int unsigned N_CHAL   = 4,
  parameter int unsigned DIGEST_W = 128,
  parameter int unsigned DISP_W   = 16,
  parameter int unsigned TIMEOUT  = 1023,
  localparam int unsigned HASH_IN_W = hash_in_width(CHAL_W, RESP_W, N_CHAL),
  localparam int unsigned N_SLICE   = DIGEST_W / DISP_W,
  localparam int unsigned SEL_W     = sel_width(N_SLICE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHAL_W-1:0]    challenge,
  input  logic                 start,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [CHAL_W-1:0]    puf_challenge,
  output logic                 puf_en,
  input  logic [RESP_W-1:0]    puf_response,
  input  logic                 puf_valid,
  output logic [HASH_IN_W-1:0] hash_data,
  output logic                 hash_start,
  input  logic                 hash_ready,
  input  logic [DIGEST_W-1:0]  hash_digest,
  output logic [RESP_W-1:0]    response,
  output logic [DISP_W-1:0]    disp,
  output logic                 busy,
  output logic                 valid,
  output logic                 err
);

  localparam int unsigned IDX_W = idx_width(N_CHAL);
  localparam int unsigned CNT_W = cnt_width(TIMEOUT);

  state_t                         state_q, state_d;
  logic [CHAL_W-1:0]              base_q, base_d;
  logic                           mode_q, mode_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           pend_q, pend_d;
  logic [CHAL_W-1:0]              chal_prev_q;
  logic [N_CHAL-1:0][RESP_W-1:0]  slots_q, slots_d;
  logic [DIGEST_W-1:0]            digest_q, digest_d;
  logic [CHAL_W-1:0]              puf_challenge_d;
  logic                           puf_en_d, hash_start_d;
  logic [HASH_IN_W-1:0]           hash_data_d, hash_pack;
  logic [RESP_W-1:0]              response_d;
  logic                           busy_d, valid_d, err_d;
  logic                           chal_chg, idle_like, timed_out;

  assign chal_chg  = (challenge != chal_prev_q);
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT));

  // Hash input as it will look once the response arriving this cycle is stored.
  always_comb begin
    hash_pack = '0;
    hash_pack[HASH_IN_W-1 -: CHAL_W] = base_q;
    if (mode_q) begin
      for (int i = 0; i < N_CHAL; i++) begin
        hash_pack[HASH_IN_W-CHAL_W-1-i*RESP_W -: RESP_W] =
          (IDX_W'(i) == idx_q) ? puf_response : slots_q[i];
      end
    end else begin
      hash_pack[HASH_IN_W-CHAL_W-1 -: RESP_W] = puf_response;
    end
  end

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    mode_d          = mode_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    pend_d          = pend_q;
    slots_d         = slots_q;
    digest_d        = digest_q;
    puf_challenge_d = puf_challenge;
    puf_en_d        = 1'b0;
    hash_start_d    = 1'b0;
    hash_data_d     = hash_data;
    response_d      = response;
    valid_d         = valid;
    err_d           = err;

    case (state_q)
      ST_PUF_REQ: begin
        state_d = ST_PUF_WAIT;
        cnt_d   = '0;
      end
      ST_PUF_WAIT: begin
        if (puf_valid) begin
          slots_d[idx_q] = puf_response;
          response_d     = puf_response;
          if (mode_q && (idx_q < IDX_W'(N_CHAL - 1))) begin
            idx_d           = idx_q + 1'b1;
            puf_challenge_d = base_q + CHAL_W'(idx_q + 1'b1);
            puf_en_d        = 1'b1;
            state_d         = ST_PUF_REQ;
          end else begin
            hash_data_d  = hash_pack;
            hash_start_d = 1'b1;
            state_d      = ST_HASH_REQ;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HASH_REQ: begin
        state_d = ST_HASH_WAIT;
        cnt_d   = '0;
      end
      ST_HASH_WAIT: begin
        if (hash_ready) begin
          digest_d = hash_digest;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else if (timed_out) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Challenge edits during a run are remembered and replayed once DONE is reached.
    if (!idle_like && chal_chg) pend_d = 1'b1;

    if (idle_like && (start || chal_chg || pend_q)) begin
      base_d          = challenge;
      mode_d          = mode;
      idx_d           = '0;
      pend_d          = 1'b0;
      valid_d         = 1'b0;
      err_d           = 1'b0;
      puf_challenge_d = challenge;
      puf_en_d        = 1'b1;
      state_d         = ST_PUF_REQ;
    end

    busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE));
  end

  always_ff @(posedge clk) begin
    chal_prev_q <= challenge;
    if (reset) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      mode_q        <= 1'b0;
      idx_q         <= '0;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      slots_q       <= '0;
      digest_q      <= '0;
      puf_challenge <= '0;
      puf_en        <= 1'b0;
      hash_data     <= '0;
      hash_start    <= 1'b0;
      response      <= '0;
      busy          <= 1'b0;
      valid         <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      mode_q        <= mode_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      slots_q       <= slots_d;
      digest_q      <= digest_d;
      puf_challenge <= puf_challenge_d;
      puf_en        <= puf_en_d;
      hash_data     <= hash_data_d;
      hash_start    <= hash_start_d;
      response      <= response_d;
      busy          <= busy_d;
      valid         <= valid_d;
      err           <= err_d;
    end
  end

  puf_disp_mux #(
    .CHAL_W  (CHAL_W),
    .RESP_W  (RESP_W),
    .DIGEST_W(DIGEST_W),
    .DISP_W  (DISP_W),
    .SEL_W   (SEL_W)
  ) u_disp_mux (
    .clk     (clk),
    .reset   (reset),
    .base    (base_q),
    .response(response),
    .digest  (digest_q),
    .sel     (sel),
    .disp    (disp)
  );

endmodule

// File: tb/tb_puf_hash_engine.sv
// Directed bench for puf_hash_engine with simple PUF/hash responders.
module tb_puf_hash_engine;

  logic         clk;
  logic         reset;
  logic [7:0]   challenge;
  logic         start;
  logic         mode;
  logic [3:0]   sel;
  logic [7:0]   puf_challenge;
  logic         puf_en;
  logic [7:0]   puf_response;
  logic         puf_valid;
  logic [39:0]  hash_data;
  logic         hash_start;
  logic         hash_ready;
  logic [127:0] hash_digest;
  logic [7:0]   response;
  logic [15:0]  disp;
  logic         busy, valid, err;

  int tests = 0;
  int fails = 0;

  logic [7:0]   en_log [16];
  int           n_en = 0;
  int           n_hs = 0;
  logic [39:0]  hd_cap = '0;
  bit           puf_auto = 1'b1;
  bit           hash_auto = 1'b1;
  bit           en_seen = 1'b0;
  bit           hs_seen = 1'b0;
  logic [7:0]   resp_tab [8];
  int           resp_ptr = 0;
  logic [127:0] digest_val = 128'h0123_4567_89AB_1357_9BDF_2468_ACE0_CDEF;

  puf_hash_engine #(
    .CHAL_W(8), .RESP_W(8), .N_CHAL(4), .DIGEST_W(128), .DISP_W(16), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .challenge(challenge), .start(start), .mode(mode), .sel(sel),
    .puf_challenge(puf_challenge), .puf_en(puf_en), .puf_response(puf_response),
    .puf_valid(puf_valid), .hash_data(hash_data), .hash_start(hash_start),
    .hash_ready(hash_ready), .hash_digest(hash_digest), .response(response),
    .disp(disp), .busy(busy), .valid(valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor plus one-cycle-latency PUF and hash responders.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (puf_en) begin
        if (n_en < 16) en_log[n_en] = puf_challenge;
        n_en++;
      end
      if (hash_start) begin hd_cap = hash_data; n_hs++; end
      if (puf_auto) begin
        puf_valid = en_seen;
        if (en_seen) begin puf_response = resp_tab[resp_ptr[2:0]]; resp_ptr++; end
      end
      en_seen = puf_en;
      if (hash_auto) begin hash_ready = hs_seen; hash_digest = digest_val; end
      hs_seen = hash_start;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; challenge = 8'h00; start = 1'b0; mode = 1'b0; sel = 4'd0;
    puf_valid = 1'b0; puf_response = 8'h00; hash_ready = 1'b0; hash_digest = '0;
    repeat (3) step();
    tests++; if ({puf_en, hash_start, busy, valid, err} !== 5'b0) begin fails++; $display("FAIL reset_flags got %b exp 00000", {puf_en, hash_start, busy, valid, err}); end
    tests++; if ({puf_challenge, response, disp} !== 32'h0) begin fails++; $display("FAIL reset_data got %h exp 0", {puf_challenge, response, disp}); end
    tests++; if (hash_data !== 40'h0) begin fails++; $display("FAIL reset_hash_data got %h exp 0", hash_data); end
    reset = 1'b0;
    repeat (3) step();
    tests++; if ({busy, puf_en} !== 2'b00) begin fails++; $display("FAIL reset_no_trigger got %b exp 00", {busy, puf_en}); end
  endtask

  task automatic test_single();
    resp_ptr = 0; resp_tab[0] = 8'hA5; n_en = 0;
    challenge = 8'h3C; mode = 1'b0; start = 1'b1;
    step();  // k: trigger sampled
    start = 1'b0;
    tests++; if ({puf_en, busy} !== 2'b11 || puf_challenge !== 8'h3C) begin fails++; $display("FAIL single_puf_req got en=%b busy=%b ch=%h exp 1 1 3c", puf_en, busy, puf_challenge); end
    step();  // k+1
    tests++; if (puf_en !== 1'b0) begin fails++; $display("FAIL single_puf_en_pulse got %b exp 0", puf_en); end
    step();  // k+2
    tests++; if (hash_start !== 1'b1 || hash_data !== 40'h3CA5000000) begin fails++; $display("FAIL single_hash_req got hs=%b data=%h exp 1 3ca5000000", hash_start, hash_data); end
    tests++; if (response !== 8'hA5) begin fails++; $display("FAIL single_response got %h exp a5", response); end
    step();  // k+3
    tests++; if ({hash_start, valid} !== 2'b00) begin fails++; $display("FAIL single_k3 got hs=%b valid=%b exp 0 0", hash_start, valid); end
    step();  // k+4
    tests++; if ({valid, busy, err} !== 3'b100) begin fails++; $display("FAIL single_done got valid/busy/err=%b exp 100", {valid, busy, err}); end
    step();
    tests++; if (disp !== 16'h3CA5) begin fails++; $display("FAIL single_disp got %h exp 3ca5", disp); end
    repeat (2) step();
    tests++; if (valid !== 1'b1 || n_en !== 1) begin fails++; $display("FAIL single_hold got valid=%b n_en=%0d exp 1 1", valid, n_en); end
  endtask

  task automatic test_batch();
    logic [7:0] exp_ch [4];
    int c;
    exp_ch = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    resp_ptr = 0; n_en = 0;
    resp_tab[0] = 8'h11; resp_tab[1] = 8'h22; resp_tab[2] = 8'h33; resp_tab[3] = 8'h44;
    challenge = 8'hFE; mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (valid !== 1'b1 && c < 40) begin step(); c++; end
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL batch_timeout got valid=%b exp 1", valid); end
    tests++; if (n_en !== 4) begin fails++; $display("FAIL batch_req_count got %0d exp 4", n_en); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (en_log[i] !== exp_ch[i]) begin fails++; $display("FAIL batch_challenge_%0d got %h exp %h", i, en_log[i], exp_ch[i]); end
    end
    tests++; if (hd_cap !== 40'hFE11223344 || hash_data !== 40'hFE11223344) begin fails++; $display("FAIL batch_hash_data got %h/%h exp fe11223344", hd_cap, hash_data); end
    tests++; if (response !== 8'h44 || err !== 1'b0) begin fails++; $display("FAIL batch_response got %h err=%b exp 44 0", response, err); end
  endtask

  task automatic test_disp();
    logic [15:0] exp_d [10];
    exp_d = '{16'hFE44, 16'hCDEF, 16'hACE0, 16'h2468, 16'h9BDF,
              16'h1357, 16'h89AB, 16'h4567, 16'h0123, 16'h0000};
    for (int s = 0; s < 10; s++) begin
      sel = 4'(s);
      repeat (2) step();
      tests++; if (disp !== exp_d[s]) begin fails++; $display("FAIL disp_sel_%0d got %h exp %h", s, disp, exp_d[s]); end
    end
    sel = 4'd15;
    repeat (2) step();
    tests++; if (disp !== 16'h0) begin fails++; $display("FAIL disp_sel_15 got %h exp 0", disp); end
  endtask

  task automatic test_timeout();
    puf_auto = 1'b0; hash_auto = 1'b0; puf_valid = 1'b0; hash_ready = 1'b0;
    challenge = 8'h55; mode = 1'b0; start = 1'b1;
    step();  // k
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 5) hash_ready = 1'b1;
      if (c == 6) hash_ready = 1'b0;
    end
    tests++; if ({busy, err} !== 2'b10) begin fails++; $display("FAIL timeout_early got busy/err=%b exp 10", {busy, err}); end
    step();  // k+17
    tests++; if ({err, valid, busy} !== 3'b100) begin fails++; $display("FAIL timeout_err got err/valid/busy=%b exp 100", {err, valid, busy}); end
    sel = 4'd8;
    puf_valid = 1'b1; puf_response = 8'h77; hash_ready = 1'b1; hash_digest = '0;
    step();
    puf_valid = 1'b0; hash_ready = 1'b0;
    repeat (2) step();
    tests++; if (response !== 8'h44 || disp !== 16'h0123) begin fails++; $display("FAIL stray_strobe got resp=%h disp=%h exp 44 0123", response, disp); end
    tests++; if ({err, valid, busy} !== 3'b100) begin fails++; $display("FAIL stray_state got err/valid/busy=%b exp 100", {err, valid, busy}); end
  endtask

  task automatic test_pending();
    int c;
    puf_auto = 1'b1; hash_auto = 1'b0; hash_ready = 1'b0;
    resp_ptr = 0; resp_tab[0] = 8'h5A; resp_tab[1] = 8'h6B; n_en = 0;
    challenge = 8'h10; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (hash_start !== 1'b1 && c < 20) begin step(); c++; end
    tests++; if (hash_start !== 1'b1) begin fails++; $display("FAIL pend_hash_start_wait got %b exp 1", hash_start); end
    step();  // now in HASH_WAIT
    challenge = 8'h20;
    repeat (3) step();
    tests++; if (busy !== 1'b1 || n_en !== 1) begin fails++; $display("FAIL pend_no_restart got busy=%b n_en=%0d exp 1 1", busy, n_en); end
    hash_ready = 1'b1; hash_digest = digest_val;
    step();
    hash_ready = 1'b0; hash_auto = 1'b1;
    tests++; if ({valid, busy} !== 2'b10) begin fails++; $display("FAIL pend_done got valid/busy=%b exp 10", {valid, busy}); end
    step();
    tests++; if ({puf_en, busy, valid} !== 3'b110 || puf_challenge !== 8'h20) begin fails++; $display("FAIL pend_retrigger got en/busy/valid=%b ch=%h exp 110 20", {puf_en, busy, valid}, puf_challenge); end
    c = 0;
    while (valid !== 1'b1 && c < 20) begin step(); c++; end
    repeat (5) step();
    tests++; if ({valid, busy} !== 2'b10 || n_en !== 2 || response !== 8'h6B) begin fails++; $display("FAIL pend_single_retrigger got valid/busy=%b n_en=%0d resp=%h exp 10 2 6b", {valid, busy}, n_en, response); end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    puf_auto = 1'b0; puf_valid = 1'b0;
    challenge = 8'h99; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_mid_busy got %b exp 1", busy); end
    step();  // PUF_WAIT
    reset = 1'b1; challenge = 8'h42;
    step();
    tests++; if ({puf_en, hash_start, busy, valid, err} !== 5'b0) begin fails++; $display("FAIL rst_mid_flags got %b exp 00000", {puf_en, hash_start, busy, valid, err}); end
    tests++; if ({puf_challenge, response, disp} !== 32'h0 || hash_data !== 40'h0) begin fails++; $display("FAIL rst_mid_data got %h %h exp 0 0", {puf_challenge, response, disp}, hash_data); end
    step();
    reset = 1'b0; n_en = 0; seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (puf_en || hash_start) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0 || busy !== 1'b0 || n_en !== 0) begin fails++; $display("FAIL rst_mid_quiet got pulse=%b busy=%b n_en=%0d exp 0 0 0", seen, busy, n_en); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_batch();
    test_disp();
    test_timeout();
    test_pending();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/puf_hash_engine.md
PUF_HASH_ENGINE -- requirements
Module: puf_hash_engine

Interface
REQ-001 Parameter CHAL_W, default 8, challenge width in bits.
REQ-002 Parameter RESP_W, default 8, PUF response width in bits.
REQ-003 Parameter N_CHAL, default 4, challenges per batch (1..16).
REQ-004 Parameter DIGEST_W, default 128, hash digest width; DISP_W, default 16, display slice width; DIGEST_W SHALL be a multiple of DISP_W.
REQ-005 Parameter TIMEOUT, default 1023, maximum cycles to wait for puf_valid or hash_ready.
REQ-006 Derived constants: HASH_IN_W = CHAL_W + N_CHAL*RESP_W; N_SLICE = DIGEST_W/DISP_W; SEL_W = clog2(N_SLICE+1).
REQ-007 Clocking: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  sole clock, all state on rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 challenge  in  CHAL_W  base challenge from user switches.
REQ-011 start  in  1  level; a trigger is sampled high.
REQ-012 mode  in  1  0 = single challenge, 1 = batch of N_CHAL; sampled at trigger.
REQ-013 sel  in  SEL_W  display selector.
REQ-014 puf_challenge  out  CHAL_W  challenge presented to the external PUF.
REQ-015 puf_en  out  1  one-cycle request pulse to the PUF.
REQ-016 puf_response  in  RESP_W  PUF result, qualified by puf_valid.
REQ-017 puf_valid  in  1  PUF result valid strobe.
REQ-018 hash_data  out  HASH_IN_W  packed hash input, held stable from hash_start until DONE.
REQ-019 hash_start  out  1  one-cycle request pulse to the hash core.
REQ-020 hash_ready  in  1  digest valid strobe; hash_digest  in  DIGEST_W  digest.
REQ-021 response  out  RESP_W  last accepted PUF response.
REQ-022 disp  out  DISP_W  selected display word; busy, valid, err  out  1 each  status.

Function
REQ-023 FSM states: IDLE, PUF_REQ, PUF_WAIT, HASH_REQ, HASH_WAIT, DONE.
REQ-024 Trigger: in IDLE or DONE, start==1 or challenge differs from its value registered on the previous cycle.
REQ-025 On trigger: latch challenge as base, latch mode, clear valid and err, set index to 0, go to PUF_REQ.
REQ-026 PUF_REQ: puf_en=1 for exactly one cycle with puf_challenge = (base + index) mod 2^CHAL_W, then go to PUF_WAIT.
REQ-027 PUF_WAIT: on puf_valid, store puf_response into slot index and into response.
- If more batch entries remain (index < N_CHAL-1 in batch mode): increment index, go to PUF_REQ.
- Otherwise go to HASH_REQ.
REQ-028 Single mode: hash_data = {base, response, zero pad} (MSB-first); batch mode: hash_data = {base, slot0 ... slot N_CHAL-1}.
REQ-029 HASH_REQ: hash_start=1 for one cycle, then go to HASH_WAIT; hash_ready SHALL be sampled only in HASH_WAIT.
REQ-030 HASH_WAIT: on hash_ready, register hash_digest, go to DONE; valid SHALL be 1 in the first DONE cycle.
REQ-031 A wait counter clears on entry to PUF_WAIT and HASH_WAIT; reaching TIMEOUT with no strobe SHALL set err=1, valid=0 and go to DONE.
REQ-032 busy=1 in every state except IDLE and DONE; triggers while busy SHALL be ignored, but a challenge change while busy SHALL set a pending flag that retriggers on entry to DONE.
REQ-033 Single-mode minimum latency: trigger at edge k, puf_en in cycle k+1, puf_valid at k+2, hash_start at k+3, hash_ready at k+4, valid=1 from k+5.
REQ-034 disp: sel==0 gives {base, response} truncated or zero-extended to DISP_W; sel==i (1..N_SLICE) gives digest[i*DISP_W-1 -: DISP_W]; other sel values give 0; disp SHALL be registered.
REQ-035 Stray puf_valid or hash_ready in any state other than its own wait state SHALL be ignored.

Reset
REQ-036 Reset SHALL force IDLE and clear index, counters, pending flag, slots, digest, response, disp, busy, valid and err.
REQ-037 Reset SHALL drive puf_en=0 and hash_start=0, including mid-operation; the previous-challenge register SHALL load challenge so that reset itself produces no trigger.

Structure
REQ-038 A shared package puf_pkg SHALL hold the FSM state enum and the derived-width helper functions.
REQ-039 One sub-module, puf_disp_mux (the sel-to-slice register), is natural; everything else stays flat.

Verification
REQ-040 Single mode, challenge=0x3C, start pulse, PUF returns 0xA5 after 1 cycle -> hash_data MSBs=0x3CA5, valid at k+5, sel=0 disp=0x3CA5.
REQ-041 Batch mode, challenge=0xFE, N_CHAL=4 -> puf_challenge sequence FE, FF, 00, 01 (wrap-around); 4 responses packed in order.
REQ-042 Digest 0x0123...CDEF, sel=1..8 -> disp equals the matching 16-bit slices; sel=9 -> disp=0.
REQ-043 PUF never asserts puf_valid, TIMEOUT=15 -> err=1 after 16 wait cycles, valid=0, FSM in DONE.
REQ-044 Change challenge during HASH_WAIT -> no restart; one automatic retrigger after DONE.
REQ-045 Reset asserted in PUF_WAIT -> IDLE next cycle, all outputs 0, no puf_en or hash_start pulse.
